ranc_grid_io_bridge: RTL and testbench

//  Host-side I/O bridge for a multi-row, multi-output RANC grid.

---
 rtl/ranc_grid_io_bridge.sv | 233 +++++++++++++++++++++++
 tb/tb_ranc_grid_io_bridge.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ranc_grid_io_bridge.sv
// ranc_grid_io_bridge: host-side I/O bridge for a multi-row, multi-output RANC grid.
//  Input side: host packets are steered into per-row FWFT FIFOs whose heads
//  drive the west-edge router port of each grid row.
//  Output side: one-cycle spike pulses from each OutputBus channel are caught
//  in a 1-entry hold register, arbitrated round-robin and merged into one
//  buffered FWFT valid/ready stream. Also keeps the tick counter and the
//  sticky error flags.
//  Optional feature macro: RANC_IO_TICK_STAMP_EN. When defined, each hold also
//  latches tick_count at capture and out_data = {tick_stamp, channel, spike}.
module ranc_grid_io_bridge #(
  parameter int NUM_ROWS         = 2,
  parameter int PACKET_WIDTH     = 30,
  parameter int IN_FIFO_DEPTH    = 4,
  parameter int NUM_OUT_CHANNELS = 2,
  parameter int NUM_OUTPUTS      = 256,
  parameter int OUT_FIFO_DEPTH   = 8,
  parameter int TICK_WIDTH       = 16,
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int CW = (NUM_OUT_CHANNELS > 1) ? $clog2(NUM_OUT_CHANNELS) : 1,
  localparam int SW = $clog2(NUM_OUTPUTS),
`ifdef RANC_IO_TICK_STAMP_EN
  localparam int OW = TICK_WIDTH + CW + SW
`else
  localparam int OW = CW + SW
`endif
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             tick,
  input  logic [PACKET_WIDTH-1:0]          host_packet,
  input  logic [RW-1:0]                    host_row,
  input  logic                             host_valid,
  output logic                             host_ready,
  output logic [NUM_ROWS*PACKET_WIDTH-1:0] row_packet,
  output logic [NUM_ROWS-1:0]              row_empty,
  input  logic [NUM_ROWS-1:0]              row_ren,
  input  logic [NUM_OUT_CHANNELS*SW-1:0]   spike_in,
  input  logic [NUM_OUT_CHANNELS-1:0]      spike_in_valid,
  output logic [OW-1:0]                    out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [TICK_WIDTH-1:0]            tick_count,
  output logic                             input_error,
  output logic                             spike_drop_error
);

  localparam int IPW = $clog2(IN_FIFO_DEPTH);
  localparam int ICW = IPW + 1;
  localparam int OPW = $clog2(OUT_FIFO_DEPTH);
  localparam int OCW = OPW + 1;

  // ---------------- input path state ----------------
  logic [PACKET_WIDTH-1:0] row_mem   [NUM_ROWS][IN_FIFO_DEPTH];
  logic [IPW-1:0]          row_wptr  [NUM_ROWS];
  logic [IPW-1:0]          row_rptr  [NUM_ROWS];
  logic [ICW-1:0]          row_count [NUM_ROWS];
  logic [NUM_ROWS-1:0]     row_push;
  logic [NUM_ROWS-1:0]     row_pop;
  logic                    row_sel_full;
  logic                    row_sel_oob;
  logic                    host_fire;

  // ---------------- output path state ----------------
  logic [NUM_OUT_CHANNELS-1:0] hold_vld;
  logic [SW-1:0]               hold_spk   [NUM_OUT_CHANNELS];
`ifdef RANC_IO_TICK_STAMP_EN
  logic [TICK_WIDTH-1:0]       hold_stamp [NUM_OUT_CHANNELS];
`endif
  logic [NUM_OUT_CHANNELS-1:0] hold_load;
  logic [NUM_OUT_CHANNELS-1:0] hold_grant;
  logic [CW-1:0]               rr_ptr;
  logic [CW-1:0]               grant_idx;
  logic                        grant_vld;
  logic                        grant_en;
  logic                        out_room;
  logic                        out_pop;
  int                          arb_cand;
  logic [OW-1:0]               out_entry;
  logic [OW-1:0]               out_mem [OUT_FIFO_DEPTH];
  logic [OPW-1:0]              out_wptr;
  logic [OPW-1:0]              out_rptr;
  logic [OCW-1:0]              out_count;

  // Host admission: a row is full on its registered count only; out-of-range rows are always taken
  always_comb begin
    row_sel_oob  = (int'(host_row) >= NUM_ROWS);
    row_sel_full = 1'b0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (host_row == RW'(r) && row_count[r] == ICW'(IN_FIFO_DEPTH)) row_sel_full = 1'b1;
    end
  end

  assign host_ready = !rst && (row_sel_oob || !row_sel_full);
  assign host_fire  = host_valid && host_ready;

  // Per-row push/pop strobes; a pop on an empty row is ignored
  always_comb begin
    row_push = '0;
    row_pop  = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      row_push[r] = host_fire && (host_row == RW'(r));
      row_pop[r]  = row_ren[r] && (row_count[r] != '0);
    end
  end

  // Row FIFO storage (data only, never reset)
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_push[r]) row_mem[r][row_wptr[r]] <= host_packet;
    end
  end

  // Row FIFO pointers and occupancy; rst discards everything buffered
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        row_wptr[r]  <= '0;
        row_rptr[r]  <= '0;
        row_count[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (row_push[r]) row_wptr[r] <= row_wptr[r] + IPW'(1);
        if (row_pop[r])  row_rptr[r] <= row_rptr[r] + IPW'(1);
        if (row_push[r] && !row_pop[r])      row_count[r] <= row_count[r] + ICW'(1);
        else if (!row_push[r] && row_pop[r]) row_count[r] <= row_count[r] - ICW'(1);
      end
    end
  end

  // FWFT heads and empty flags toward the west router ports
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row_out
    assign row_packet[r*PACKET_WIDTH +: PACKET_WIDTH] = row_mem[r][row_rptr[r]];
    assign row_empty[r] = (row_count[r] == '0);
  end

  // Round-robin pick: scanning from the far end lets the first occupied hold at/after rr_ptr win
  always_comb begin
    arb_cand  = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_OUT_CHANNELS - 1; i >= 0; i--) begin
      arb_cand = (int'(rr_ptr) + i) % NUM_OUT_CHANNELS;
      if (hold_vld[arb_cand]) begin
        grant_vld = 1'b1;
        grant_idx = CW'(arb_cand);
      end
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still take a grant
  assign out_pop  = out_valid && out_ready;
  assign out_room = (out_count != OCW'(OUT_FIFO_DEPTH)) || out_pop;
  assign grant_en = grant_vld && out_room;

  // Hold load decision: empty holds, or the hold being granted this cycle, may take a new spike
  always_comb begin
    hold_grant = '0;
    hold_load  = '0;
    for (int c = 0; c < NUM_OUT_CHANNELS; c++) begin
      hold_grant[c] = grant_en && (grant_idx == CW'(c));
      hold_load[c]  = spike_in_valid[c] && (!hold_vld[c] || hold_grant[c]);
    end
  end

`ifdef RANC_IO_TICK_STAMP_EN
  assign out_entry = {hold_stamp[grant_idx], grant_idx, hold_spk[grant_idx]};
`else
  assign out_entry = {grant_idx, hold_spk[grant_idx]};
`endif

  // Hold payload capture (data only, never reset); the stamp is the pre-increment tick_count
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_OUT_CHANNELS; c++) begin
      if (hold_load[c]) begin
        hold_spk[c] <= spike_in[c*SW +: SW];
`ifdef RANC_IO_TICK_STAMP_EN
        hold_stamp[c] <= tick_count;
`endif
      end
    end
  end

  // Hold occupancy, round-robin pointer and the sticky drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld         <= '0;
      rr_ptr           <= '0;
      spike_drop_error <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_OUT_CHANNELS; c++) begin
        if (hold_load[c])       hold_vld[c] <= 1'b1;
        else if (hold_grant[c]) hold_vld[c] <= 1'b0;
        if (spike_in_valid[c] && !hold_load[c]) spike_drop_error <= 1'b1;
      end
      if (grant_en) rr_ptr <= (grant_idx == CW'(NUM_OUT_CHANNELS - 1)) ? '0 : grant_idx + CW'(1);
    end
  end

  // Merged FIFO storage (data only, never reset)
  always_ff @(posedge clk) begin
    if (grant_en) out_mem[out_wptr] <= out_entry;
  end

  // Merged FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      out_wptr  <= '0;
      out_rptr  <= '0;
      out_count <= '0;
    end else begin
      if (grant_en) out_wptr <= out_wptr + OPW'(1);
      if (out_pop)  out_rptr <= out_rptr + OPW'(1);
      if (grant_en && !out_pop)      out_count <= out_count + OCW'(1);
      else if (!grant_en && out_pop) out_count <= out_count - OCW'(1);
    end
  end

  assign out_valid = (out_count != '0);
  assign out_data  = out_mem[out_rptr];

  // Tick counter (wraps naturally) and sticky host-row error
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_count  <= '0;
      input_error <= 1'b0;
    end else begin
      if (tick) tick_count <= tick_count + TICK_WIDTH'(1);
      if (host_fire && row_sel_oob) input_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ranc_grid_io_bridge.sv
// tb_ranc_grid_io_bridge: directed bench for ranc_grid_io_bridge with a
// queue-based reference model checked every cycle, plus literal expectations.
// Built with NUM_ROWS=3 so an out-of-range host_row (3) is expressible, and
// TICK_WIDTH=4 so the tick wrap is reachable. Honours RANC_IO_TICK_STAMP_EN.
module tb_ranc_grid_io_bridge;

  localparam int NR = 3;
  localparam int PW = 30;
  localparam int ID = 4;
  localparam int NC = 2;
  localparam int NO = 256;
  localparam int OD = 8;
  localparam int TW = 4;
  localparam int RW = 2;
  localparam int CW = 1;
  localparam int SW = 8;
`ifdef RANC_IO_TICK_STAMP_EN
  localparam int OWB = TW + CW + SW;
`else
  localparam int OWB = CW + SW;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tick = 1'b0;
  logic [PW-1:0]     host_packet = '0;
  logic [RW-1:0]     host_row = '0;
  logic              host_valid = 1'b0;
  logic              host_ready;
  logic [NR*PW-1:0]  row_packet;
  logic [NR-1:0]     row_empty;
  logic [NR-1:0]     row_ren = '0;
  logic [NC*SW-1:0]  spike_in = '0;
  logic [NC-1:0]     spike_in_valid = '0;
  logic [OWB-1:0]    out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [TW-1:0]     tick_count;
  logic              input_error;
  logic              spike_drop_error;

  ranc_grid_io_bridge #(
    .NUM_ROWS(NR), .PACKET_WIDTH(PW), .IN_FIFO_DEPTH(ID), .NUM_OUT_CHANNELS(NC),
    .NUM_OUTPUTS(NO), .OUT_FIFO_DEPTH(OD), .TICK_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .host_packet(host_packet), .host_row(host_row), .host_valid(host_valid), .host_ready(host_ready),
    .row_packet(row_packet), .row_empty(row_empty), .row_ren(row_ren),
    .spike_in(spike_in), .spike_in_valid(spike_in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .tick_count(tick_count), .input_error(input_error), .spike_drop_error(spike_drop_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  logic [PW-1:0]  mq [NR][$];
  logic [OWB-1:0] oq [$];
  bit             m_occ   [NC];
  int             m_spk   [NC];
  int             m_stamp [NC];
  int             m_rr, m_tick;
  bit             m_ierr, m_derr;

  function automatic bit m_ready(input logic r, input logic [RW-1:0] row);
    if (r) return 1'b0;
    if (int'(row) >= NR) return 1'b1;
    return mq[row].size() < ID;
  endfunction

  function automatic logic [OWB-1:0] mk_entry(input int ch);
    logic [CW-1:0] c;
    logic [SW-1:0] s;
    c = CW'(ch);
    s = SW'(m_spk[ch]);
`ifdef RANC_IO_TICK_STAMP_EN
    return {TW'(m_stamp[ch]), c, s};
`else
    return {c, s};
`endif
  endfunction

  always @(posedge clk) begin
    bit acc, popped, room;
    int g, c;
    if (rst) begin
      for (int r = 0; r < NR; r++) mq[r].delete();
      oq.delete();
      for (int k = 0; k < NC; k++) m_occ[k] = 1'b0;
      m_rr = 0; m_tick = 0; m_ierr = 1'b0; m_derr = 1'b0;
    end else begin
      acc = host_valid && m_ready(rst, host_row);
      for (int r = 0; r < NR; r++)
        if (row_ren[r] && mq[r].size() > 0) void'(mq[r].pop_front());
      if (acc) begin
        if (int'(host_row) < NR) mq[host_row].push_back(host_packet);
        else m_ierr = 1'b1;
      end
      popped = (oq.size() > 0) && out_ready;
      room   = (oq.size() < OD) || popped;
      g = -1;
      if (room) begin
        for (int i = 0; i < NC; i++) begin
          c = (m_rr + i) % NC;
          if (g < 0 && m_occ[c]) g = c;
        end
      end
      if (popped) void'(oq.pop_front());
      if (g >= 0) begin
        oq.push_back(mk_entry(g));
        m_occ[g] = 1'b0;
        m_rr = (g + 1) % NC;
      end
      for (int k = 0; k < NC; k++) begin
        if (spike_in_valid[k]) begin
          if (!m_occ[k]) begin
            m_occ[k] = 1'b1;
            m_spk[k] = int'(spike_in[k*SW +: SW]);
            m_stamp[k] = m_tick;
          end else m_derr = 1'b1;
        end
      end
      if (tick) m_tick = (m_tick + 1) % (1 << TW);
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("host_ready", host_ready, m_ready(rst, host_row));
      for (int r = 0; r < NR; r++) begin
        chk($sformatf("row_empty%0d", r), row_empty[r], mq[r].size() == 0);
        if (mq[r].size() > 0) chk($sformatf("row_packet%0d", r), row_packet[r*PW +: PW], mq[r][0]);
      end
      chk("out_valid", out_valid, oq.size() > 0);
      if (oq.size() > 0) chk("out_data", out_data, oq[0]);
      chk("tick_count", tick_count, m_tick);
      chk("input_error", input_error, m_ierr);
      chk("spike_drop_error", spike_drop_error, m_derr);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] pk(input int i);
    return PW'(32'h0A00_0000 + i);
  endfunction

  logic [SW+CW-1:0] got [20];
  int n;

  initial begin
    // T1: reset with inputs active
    rst = 1'b1; host_valid = 1'b1; host_row = 2'd0; host_packet = 30'h155;
    spike_in = 16'h0102; spike_in_valid = 2'b11; tick = 1'b1;
    cyc(); chk_en = 1'b1; cyc(); cyc();
    chk("t1_host_ready", host_ready, 0);
    chk("t1_row_empty", row_empty, 3'b111);
    chk("t1_out_valid", out_valid, 0);
    chk("t1_tick_count", tick_count, 0);
    chk("t1_input_error", input_error, 0);
    chk("t1_drop_error", spike_drop_error, 0);
    rst = 1'b0; host_valid = 1'b0; spike_in_valid = '0; tick = 1'b0;
    cyc();

    // T2: row fill, backpressure, ordering, ignored pops, bad row
    host_row = 2'd1;
    for (int i = 0; i < 5; i++) begin
      host_packet = pk(i); host_valid = 1'b1; #1;
      chk($sformatf("t2_ready%0d", i), host_ready, (i < 4) ? 1 : 0);
      cyc();
    end
    host_valid = 1'b0;
    chk("t2_head0", row_packet[PW +: PW], pk(0));
    chk("t2_row_empty", row_empty, 3'b101);
    row_ren = 3'b010; cyc(); row_ren = '0;
    chk("t2_head1", row_packet[PW +: PW], pk(1));
    row_ren = 3'b010; cyc(); row_ren = '0;
    chk("t2_head2", row_packet[PW +: PW], pk(2));
    host_packet = pk(4); host_valid = 1'b1; row_ren = 3'b010; cyc();
    host_valid = 1'b0; row_ren = '0;
    chk("t2_pushpop_head", row_packet[PW +: PW], pk(3));
    host_packet = pk(5); host_valid = 1'b1; cyc();
    host_packet = pk(6); cyc();
    host_packet = pk(7); row_ren = 3'b010; #1;
    chk("t2_full_pop_ready", host_ready, 0);
    cyc(); host_valid = 1'b0; row_ren = '0;
    chk("t2_head4", row_packet[PW +: PW], pk(4));
    row_ren = 3'b001; cyc(); row_ren = '0;
    chk("t2_empty_pop", row_empty[0], 1);
    host_row = 2'd0; host_packet = 30'h3FFF_FFFF; host_valid = 1'b1; cyc(); host_valid = 1'b0;
    chk("t2_row0_head", row_packet[0 +: PW], 30'h3FFF_FFFF);
    chk("t2_row_empty2", row_empty, 3'b100);
    host_row = 2'd3; host_packet = 30'h123; host_valid = 1'b1; #1;
    chk("t2_bad_row_ready", host_ready, 1);
    cyc(); host_valid = 1'b0;
    chk("t2_input_error", input_error, 1);
    chk("t2_row_empty3", row_empty, 3'b100);

    // T3: simultaneous spikes and round-robin
    out_ready = 1'b1;
    spike_in = {8'd9, 8'd5}; spike_in_valid = 2'b11; cyc(); spike_in_valid = '0;
    chk("t3_latency", out_valid, 0);
    cyc();
    chk("t3_valid", out_valid, 1);
    chk("t3_first", out_data[CW+SW-1:0], 9'h005);
    cyc();
    chk("t3_second", out_data[CW+SW-1:0], 9'h109);
    cyc();
    chk("t3_drained", out_valid, 0);
    spike_in = {8'd0, 8'd7}; spike_in_valid = 2'b01; cyc(); spike_in_valid = '0;
    cyc(); cyc();
    spike_in = {8'd4, 8'd3}; spike_in_valid = 2'b11; cyc(); spike_in_valid = '0;
    cyc();
    chk("t3_rr_first", out_data[CW+SW-1:0], 9'h104);
    cyc();
    chk("t3_rr_second", out_data[CW+SW-1:0], 9'h003);
    cyc();
    chk("t3_no_drop", spike_drop_error, 0);

    // T4: merged FIFO full, one held, one dropped, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      spike_in = {8'd0, 8'(20 + i)}; spike_in_valid = 2'b01; cyc();
    end
    spike_in_valid = '0;
    chk("t4_drop", spike_drop_error, 1);
    chk("t4_valid", out_valid, 1);
    chk("t4_head", out_data[CW+SW-1:0], 9'h014);
    cyc();
    out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) got[k] = '0;
    for (int k = 0; k < 20; k++) begin
      if (!out_valid) break;
      got[n] = out_data[CW+SW-1:0];
      n++;
      cyc();
    end
    chk("t4_drain_count", n, 9);
    for (int j = 0; j < 9; j++) chk($sformatf("t4_drain%0d", j), got[j], 9'(20 + j));

    // T5: tick wrap and capture stamp
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick = 1'b1; cyc();
    end
    tick = 1'b0;
    chk("t5_tick_wrap", tick_count, 1);
    chk("t5_err_cleared", spike_drop_error, 0);
    out_ready = 1'b0;
    tick = 1'b1; spike_in = {8'h33, 8'h00}; spike_in_valid = 2'b10; cyc();
    tick = 1'b0; spike_in_valid = '0; cyc();
    chk("t5_tick_after", tick_count, 2);
    chk("t5_spike", out_data[CW+SW-1:0], 9'h133);
`ifdef RANC_IO_TICK_STAMP_EN
    chk("t5_stamp", out_data[OWB-1 -: TW], 1);
`endif
    out_ready = 1'b1; cyc(); out_ready = 1'b0;

    // T6: reset mid-stream
    host_valid = 1'b1; host_row = 2'd0; host_packet = 30'h0AA; cyc();
    host_packet = 30'h0AB; cyc();
    host_row = 2'd1; host_packet = 30'h0BB; cyc();
    host_valid = 1'b0;
    spike_in = {8'd2, 8'd1}; spike_in_valid = 2'b11; cyc(); cyc();
    spike_in_valid = '0;
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t6_row_empty", row_empty, 3'b111);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_tick", tick_count, 0);
    chk("t6_drop_clear", spike_drop_error, 0);
    cyc();
    chk("t6_holds_clear", out_valid, 0);
    host_row = 2'd2; host_packet = 30'h2C0FFEE; host_valid = 1'b1; cyc(); host_valid = 1'b0;
    chk("t6_row2_head", row_packet[2*PW +: PW], 30'h2C0FFEE);
    spike_in = {8'h44, 8'h00}; spike_in_valid = 2'b10; cyc(); spike_in_valid = '0; cyc();
    chk("t6_spike", out_data[CW+SW-1:0], 9'h144);
    chk("t6_out_valid2", out_valid, 1);
    cyc(); cyc();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
